// File: rtl/mac_l1_delay_comp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mac_l1_delay_comp_pkg
//  Purpose  : Shared widths and FSM encoding for the MAC L1 delay compensator
//  Revision : 1.0  initial release
// ============================================================================
package mac_l1_delay_comp_pkg;

    localparam int c_MAC_L1_WIDTH = 16;
    localparam int c_MAC_L1_DEPTH = 16;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mac_l1_delay_ram.sv
`default_nettype none
// ============================================================================
//  Module   : mac_l1_delay_ram
//  Purpose  : Circular word store, sync write / async read, resettable valid tags
//  Revision : 1.0  initial release
// ============================================================================
module mac_l1_delay_ram
    import mac_l1_delay_comp_pkg::*;
#(
    parameter int WIDTH     = c_MAC_L1_WIDTH,
    parameter int MAX_DEPTH = c_MAC_L1_DEPTH,
    parameter int DEPTH_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DEPTH_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               wr_valid,
    input  logic [DEPTH_W-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_valid
);

    logic [WIDTH-1:0]     r_data [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] r_valid;

    // Only the tag column is cleared; data is always masked by its tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid[wr_addr] <= wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        r_data[wr_addr] <= wr_data;
    end

    assign rd_data  = r_data[rd_addr];
    assign rd_valid = r_valid[rd_addr];

endmodule
`default_nettype wire

// File: rtl/mac_l1_delay_comp.sv
`default_nettype none
// ============================================================================
//  Module   : mac_l1_delay_comp
//  Purpose  : Run-time programmable 1..16 cycle re-timer with lock-qualified output
//  Revision : 1.0  initial release
// ============================================================================
module mac_l1_delay_comp
    import mac_l1_delay_comp_pkg::*;
#(
    parameter int WIDTH         = c_MAC_L1_WIDTH,
    parameter int MAX_DEPTH     = c_MAC_L1_DEPTH,
    parameter int DEPTH_W       = 4,
    parameter int DEFAULT_DELAY = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               in_valid,
    input  logic [DEPTH_W-1:0] delay_cfg,
    input  logic               cfg_load,
    output logic [WIDTH-1:0]   data_out,
    output logic               out_valid,
    output logic               locked,
    output logic [DEPTH_W-1:0] active_delay
);

    localparam logic [DEPTH_W-1:0] c_DEFAULT = DEPTH_W'(DEFAULT_DELAY);

    state_t             r_state;
    state_t             w_state_nxt;
    state_t             w_eff_state;
    logic [DEPTH_W-1:0] r_wp;
    logic [DEPTH_W-1:0] r_fill_cnt;
    logic [DEPTH_W-1:0] w_fill_nxt;
    logic [DEPTH_W-1:0] r_active_delay;
    logic [DEPTH_W-1:0] w_eff_delay;
    logic [DEPTH_W-1:0] w_eff_cnt;
    logic [DEPTH_W-1:0] w_ra;
    logic [WIDTH-1:0]   w_ram_data;
    logic               w_ram_valid;
    logic [WIDTH-1:0]   w_rd_data;
    logic               w_rd_valid;
    logic               w_qualify;
    logic               w_emit;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_out_valid;

    // The load edge itself is fill step 0 under the new delay, so a D=1
    // load can already present the word sampled on that same edge.
    assign w_eff_delay = cfg_load ? delay_cfg : r_active_delay;
    assign w_eff_cnt   = cfg_load ? '0        : r_fill_cnt;
    assign w_eff_state = cfg_load ? ST_FILL   : r_state;

    assign w_ra = r_wp - w_eff_delay;

    mac_l1_delay_ram #(
        .WIDTH     (WIDTH),
        .MAX_DEPTH (MAX_DEPTH),
        .DEPTH_W   (DEPTH_W)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_addr  (r_wp),
        .wr_data  (data_in),
        .wr_valid (in_valid),
        .rd_addr  (w_ra),
        .rd_data  (w_ram_data),
        .rd_valid (w_ram_valid)
    );

    // Zero delay would read the slot being written this edge.
    assign w_rd_data  = (w_eff_delay == '0) ? data_in  : w_ram_data;
    assign w_rd_valid = (w_eff_delay == '0) ? in_valid : w_ram_valid;

    always_comb begin
        w_state_nxt = w_eff_state;
        w_fill_nxt  = w_eff_cnt;
        w_qualify   = 1'b0;
        case (w_eff_state)
            ST_FILL: begin
                if (w_eff_cnt == w_eff_delay) begin
                    w_state_nxt = ST_RUN;
                    w_qualify   = 1'b1;
                end else begin
                    w_fill_nxt = w_eff_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                w_qualify = 1'b1;
            end
            default: begin
                w_state_nxt = ST_FILL;
                w_fill_nxt  = '0;
            end
        endcase
    end

    assign w_emit = w_qualify & w_rd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_FILL;
            r_fill_cnt     <= '0;
            r_wp           <= '0;
            r_active_delay <= c_DEFAULT;
            r_out_valid    <= 1'b0;
            r_data_out     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill_cnt  <= w_fill_nxt;
            r_wp        <= r_wp + 1'b1;
            r_out_valid <= w_emit;
            r_data_out  <= w_emit ? w_rd_data : '0;
            if (cfg_load) begin
                r_active_delay <= delay_cfg;
            end
        end
    end

    assign data_out     = r_data_out;
    assign out_valid    = r_out_valid;
    assign locked       = (r_state == ST_RUN);
    assign active_delay = r_active_delay;

endmodule
`default_nettype wire

// File: tb/tb_mac_l1_delay_comp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_l1_delay_comp
//  Purpose  : Randomized scoreboard bench for mac_l1_delay_comp
//  Revision : 1.0  initial release
// ============================================================================
module tb_mac_l1_delay_comp;

    localparam int c_HIST = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  delay_cfg = '0;
    logic        cfg_load = 1'b0;
    logic [15:0] data_out;
    logic        out_valid;
    logic        locked;
    logic [3:0]  active_delay;

    always #5 clk = ~clk;

    mac_l1_delay_comp dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .in_valid     (in_valid),
        .delay_cfg    (delay_cfg),
        .cfg_load     (cfg_load),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .locked       (locked),
        .active_delay (active_delay)
    );

    typedef struct packed {
        logic        v;
        logic [15:0] d;
        logic        lk;
        logic [3:0]  ad;
    } exp_t;

    exp_t        sb[$];
    logic [16:0] hist [c_HIST];
    int          cyc = 0;
    int          epoch = 0;
    int          dly = 6;
    int          n_vec = 0;
    int          n_err = 0;
    bit          done = 1'b0;

    // Reference: the output after edge k is the input of edge k+1-D,
    // provided that input belongs to the current epoch (since last rst/load).
    task automatic step(input logic r, input logic v, input logic [15:0] d,
                        input logic ld, input logic [3:0] cfg);
        exp_t        e;
        logic [16:0] h;
        int          n;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        data_in   = d;
        cfg_load  = ld;
        delay_cfg = cfg;
        hist[cyc % c_HIST] = {v, d};
        if (r) begin
            epoch = cyc + 1;
            dly   = 6;
        end else if (ld) begin
            epoch = cyc;
            dly   = int'(cfg) + 1;
        end
        n = cyc + 1 - epoch;
        if (n >= dly) begin
            h    = hist[(cyc + 1 - dly) % c_HIST];
            e.v  = h[16];
            e.d  = h[16] ? h[15:0] : 16'h0000;
            e.lk = 1'b1;
        end else begin
            e.v  = 1'b0;
            e.d  = 16'h0000;
            e.lk = 1'b0;
        end
        e.ad = 4'(dly - 1);
        sb.push_back(e);
        cyc++;
    endtask

    task automatic run_rand(input int cycles, input int hole_pct);
        for (int i = 0; i < cycles; i++)
            step(1'b0, ($urandom_range(99) >= hole_pct), 16'($urandom),
                 1'b0, 4'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (out_valid !== e.v || data_out !== e.d ||
                    locked !== e.lk || active_delay !== e.ad) begin
                    n_err++;
                    $display("FAIL vec%0d: got v=%0b d=%h lk=%0b ad=%0d, expected v=%0b d=%h lk=%0b ad=%0d",
                             n_vec, out_valid, data_out, locked, active_delay,
                             e.v, e.d, e.lk, e.ad);
                end
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'hdead, 1'b0, 4'd0);

        // default latency, counting pattern
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 16'(i), 1'b0, 4'($urandom));

        // holes at input cycles 3 and 4 with D = 6
        step(1'b1, 1'b1, 16'hbeef, 1'b0, 4'd0);
        for (int i = 0; i < 30; i++)
            step(1'b0, !(i == 3 || i == 4), 16'(16'h100 + i), 1'b0, 4'd0);

        // minimum latency via bypass
        step(1'b0, 1'b1, 16'h1234, 1'b1, 4'd0);
        run_rand(30, 10);

        // maximum latency across wp wrap
        step(1'b0, 1'b1, 16'h4321, 1'b1, 4'd15);
        run_rand(50, 10);

        // mid-stream reconfigure 6 -> 3
        step(1'b0, 1'b1, 16'($urandom), 1'b1, 4'd5);
        run_rand(20, 0);
        step(1'b0, 1'b1, 16'($urandom), 1'b1, 4'd2);
        run_rand(20, 0);

        // cfg_load coincident with rst
        step(1'b1, 1'b1, 16'($urandom), 1'b1, 4'd9);
        run_rand(20, 0);

        // repeated loads during fill
        step(1'b0, 1'b1, 16'($urandom), 1'b1, 4'd10);
        run_rand(3, 0);
        step(1'b0, 1'b1, 16'($urandom), 1'b1, 4'd10);
        run_rand(4, 0);
        step(1'b0, 1'b1, 16'($urandom), 1'b1, 4'd7);
        run_rand(25, 0);

        // reset mid-run
        step(1'b1, 1'b1, 16'($urandom), 1'b0, 4'd0);
        run_rand(30, 0);

        // random soak: loads, resets and holes
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(149) == 0)
                step(1'b1, 1'b1, 16'($urandom), $urandom_range(1) == 1, 4'($urandom));
            else if ($urandom_range(39) == 0)
                step(1'b0, ($urandom_range(3) != 0), 16'($urandom), 1'b1, 4'($urandom));
            else
                step(1'b0, ($urandom_range(3) != 0), 16'($urandom), 1'b0, 4'($urandom));
        end

        step(1'b0, 1'b0, 16'h0, 1'b0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
